// File: rtl/aes_pkg.sv
// AES constants shared by the key schedule and cipher datapath.
package aes_pkg;

  // Forward S-box; entry 0 is the leftmost byte of the first row.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

endpackage

// File: rtl/key_expansion.sv
// AES-128 iterative key schedule: one round key per cycle through a single
// shared SubWord (4 S-box lookups), 11 x 128-bit round-key storage, and a
// combinational read port for add_round_key.
module key_expansion
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out
);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t              state, state_nx;
  logic [3:0]          cnt;
  logic [10:0][127:0]  rk;
  logic                go;
  logic [3:0]          pidx;
  logic [127:0]        prev, nk;
  logic [31:0]         w0, w1, w2, w3, rot, sub, t;
  logic [7:0]          rcon;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state: start is honoured only outside EXPAND; the write of rk[10]
  // is the last EXPAND cycle.
  always_comb begin
    state_nx = state;
    go       = 1'b0;
    case (state)
      IDLE, DONE: if (start) begin
        go       = 1'b1;
        state_nx = EXPAND;
      end
      EXPAND: if (cnt == 4'd10) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == EXPAND);
  assign done = (state == DONE);

  // Round constant for the round key being produced.
  always_comb begin
    rcon = 8'h00;
    case (cnt)
      4'd1:  rcon = 8'h01;
      4'd2:  rcon = 8'h02;
      4'd3:  rcon = 8'h04;
      4'd4:  rcon = 8'h08;
      4'd5:  rcon = 8'h10;
      4'd6:  rcon = 8'h20;
      4'd7:  rcon = 8'h40;
      4'd8:  rcon = 8'h80;
      4'd9:  rcon = 8'h1b;
      4'd10: rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // Shared round function: rk[cnt] from rk[cnt-1]; the guard keeps the
  // previous-key select in range while cnt is 0 in IDLE.
  assign pidx = cnt - 4'd1;
  assign prev = (pidx <= 4'd9) ? rk[pidx] : '0;
  assign w0   = prev[31:0];
  assign w1   = prev[63:32];
  assign w2   = prev[95:64];
  assign w3   = prev[127:96];
  assign rot  = {w3[7:0], w3[31:8]};
  assign sub  = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};
  assign t    = sub ^ {24'h0, rcon};
  always_comb begin
    nk[31:0]   = w0 ^ t;
    nk[63:32]  = w1 ^ nk[31:0];
    nk[95:64]  = w2 ^ nk[63:32];
    nk[127:96] = w3 ^ nk[95:64];
  end

  // Key storage and round counter; only the FSM writes here.
  always_ff @(posedge clk) begin
    if (rst) begin
      rk  <= '0;
      cnt <= 4'd0;
    end else if (go) begin
      rk[0] <= key_in;
      cnt   <= 4'd1;
    end else if (state == EXPAND) begin
      rk[cnt] <= nk;
      cnt     <= cnt + 4'd1;
    end
  end

  // Combinational read; indices past the last round key read as zero.
  assign rk_out = (rk_idx <= 4'd10) ? rk[rk_idx] : '0;

endmodule
